// File: rtl/vga_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vga_mode_sequencer
// Purpose  : Streams one of two stored timing tables into VGA_Control over the
//            C_valid/C_addr/C_data/C_rdy config port on a mode request.
// Options  : define VGA_MODE_SYNC_WAIT_EN to hold writes until a VSync falling
//            edge so timing changes land on a frame boundary.
// Revision : 1.0  initial release
// ============================================================================
module vga_mode_sequencer #(
    parameter int                                CONFIG_WIDTH = 4,
    parameter int                                NUM_REGS     = 8,
    parameter logic [CONFIG_WIDTH-1:0]           BASE_ADDR    = 4'b1000,
    parameter logic [NUM_REGS*CONFIG_WIDTH-1:0]  MODE0_TABLE  = 32'hCA018721,
    parameter logic [NUM_REGS*CONFIG_WIDTH-1:0]  MODE1_TABLE  = 32'hEC127632
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode_req,
    input  logic                    mode_sel,
    input  logic                    VSync,
    input  logic                    C_rdy,
    output logic                    C_valid,
    output logic [CONFIG_WIDTH-1:0] C_addr,
    output logic [CONFIG_WIDTH-1:0] C_data,
    output logic                    busy,
    output logic                    done,
    output logic                    cur_mode
);

    localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tgt_q, tgt_d;
    logic              pend_q, pend_d;
    logic              pend_sel_q, pend_sel_d;
    logic              cur_mode_q, cur_mode_d;

    logic              start_req;
    logic              start_sel;
    logic              xfer;
    logic [NUM_REGS*CONFIG_WIDTH-1:0] table_sel;

`ifdef VGA_MODE_SYNC_WAIT_EN
    localparam logic [1:0] S_SYNC_WAIT = 2'd1;
    localparam logic [1:0] S_START     = S_SYNC_WAIT;

    logic vsync_q;
    logic vsync_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= VSync;
        end
    end

    assign vsync_fall = vsync_q & ~VSync;
`else
    localparam logic [1:0] S_START = S_WRITE;

    logic unused_vsync;
    assign unused_vsync = VSync;
`endif

    assign xfer      = (state_q == S_WRITE) && C_rdy;
    // A live request in the same cycle overrides an older pending one.
    assign start_req = mode_req | pend_q;
    assign start_sel = mode_req ? mode_sel : pend_sel_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        cur_mode_d = cur_mode_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_req) begin
                    state_d = S_START;
                    idx_d   = '0;
                    tgt_d   = start_sel;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef VGA_MODE_SYNC_WAIT_EN
            S_SYNC_WAIT: begin
                if (vsync_fall) begin
                    state_d = S_WRITE;
                end
            end
`endif
            S_WRITE: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_DONE;
                        idx_d      = '0;
                        cur_mode_d = tgt_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mode_req && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            pend_d     = 1'b1;
            pend_sel_d = mode_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tgt_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            cur_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            cur_mode_q <= cur_mode_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign table_sel = tgt_q ? MODE1_TABLE : MODE0_TABLE;
    assign C_valid   = (state_q == S_WRITE);
    assign C_addr    = BASE_ADDR + CONFIG_WIDTH'(idx_q);
    assign C_data    = C_valid ? table_sel[int'(idx_q)*CONFIG_WIDTH +: CONFIG_WIDTH] : '0;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign cur_mode  = cur_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_sequencer.sv
`default_nettype none
// Bench for vga_mode_sequencer: transaction-level reference model compared
// every cycle, plus directed scenarios with literal expected transfer logs.
module tb_vga_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_req;
    logic       mode_sel;
    logic       VSync;
    logic       C_rdy;
    logic       C_valid;
    logic [3:0] C_addr;
    logic [3:0] C_data;
    logic       busy;
    logic       done;
    logic       cur_mode;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int E0 [8] = '{1, 2, 7, 8, 1, 0, 10, 12};
    int E1 [8] = '{2, 3, 6, 7, 2, 1, 12, 14};

    int xc [$];
    int xa [$];
    int xd [$];
    int dn [$];

    always #5 clk = ~clk;

    vga_mode_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
        .VSync    (VSync),
        .C_rdy    (C_rdy),
        .C_valid  (C_valid),
        .C_addr   (C_addr),
        .C_data   (C_data),
        .busy     (busy),
        .done     (done),
        .cur_mode (cur_mode)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int spec_word(input int sel, input int i);
        logic [31:0] t;
        t = (sel != 0) ? 32'hEC127632 : 32'hCA018721;
        return int'((t >> (4 * i)) & 32'hF);
    endfunction

    // Model position: -1 idle, -2 waiting for frame edge, 0..7 word on the bus, 8 done pulse.
`ifdef VGA_MODE_SYNC_WAIT_EN
    localparam int M_FIRST = -2;
`else
    localparam int M_FIRST = 0;
`endif
    int m_pos     = -1;
    int m_sel     = 0;
    bit m_cur     = 1'b0;
    bit m_pend    = 1'b0;
    bit m_psel    = 1'b0;
    bit m_prev_vs = 1'b0;
    bit m_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos     <= -1;
            m_sel     <= 0;
            m_cur     <= 1'b0;
            m_pend    <= 1'b0;
            m_psel    <= 1'b0;
            m_prev_vs <= 1'b0;
        end else begin
            m_prev_vs <= VSync;
            if (m_pos >= 0 && m_pos < 8) begin
                if (C_rdy) begin
                    if (m_pos == 7) begin
                        m_pos <= 8;
                        m_cur <= (m_sel != 0);
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
                if (mode_req) begin
                    m_pend <= 1'b1;
                    m_psel <= mode_sel;
                end
            end else if (m_pos == -2) begin
                if (m_prev_vs && !VSync) m_pos <= 0;
                if (mode_req) begin
                    m_pend <= 1'b1;
                    m_psel <= mode_sel;
                end
            end else begin
                if (mode_req || m_pend) begin
                    m_sel  <= mode_req ? int'(mode_sel) : int'(m_psel);
                    m_pend <= 1'b0;
                    m_pos  <= M_FIRST;
                end else begin
                    m_pos <= -1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        m_wr = (m_pos >= 0 && m_pos < 8);
        chk("cmp_C_valid", int'(C_valid), int'(m_wr));
        chk("cmp_busy", int'(busy), int'(m_wr || m_pos == -2));
        chk("cmp_done", int'(done), int'(m_pos == 8));
        chk("cmp_cur_mode", int'(cur_mode), int'(m_cur));
        chk("cmp_C_addr", int'(C_addr), m_wr ? 8 + m_pos : 8);
        chk("cmp_C_data", int'(C_data), m_wr ? spec_word(m_sel, m_pos) : 0);
        if (rst_n && C_valid && C_rdy) begin
            xc.push_back(cyc);
            xa.push_back(int'(C_addr));
            xd.push_back(int'(C_data));
        end
        if (rst_n && done) dn.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xc.delete();
        xa.delete();
        xd.delete();
        dn.delete();
    endtask

    task automatic check_seq(input string nm, input int off, input int sel, input int c_first);
        chk({nm, "_count"}, int'(xa.size() >= off + 8), 1);
        for (int i = 0; i < 8; i++) begin
            if (off + i < xa.size()) begin
                chk({nm, "_addr"}, xa[off + i], 8 + i);
                chk({nm, "_data"}, xd[off + i], (sel != 0) ? E1[i] : E0[i]);
                chk({nm, "_cyc"}, xc[off + i], c_first + i);
            end
        end
    endtask

    int c0;

    initial begin
        rst_n    = 1'b0;
        mode_req = 1'b0;
        mode_sel = 1'b0;
        VSync    = 1'b1;
        C_rdy    = 1'b1;
        repeat (3) tick();
        chk("rst_C_valid", int'(C_valid), 0);
        chk("rst_C_addr", int'(C_addr), 8);
        chk("rst_C_data", int'(C_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cur_mode", int'(cur_mode), 0);
        rst_n = 1'b1;
        repeat (2) tick();

`ifndef VGA_MODE_SYNC_WAIT_EN
        // Mode 0, C_rdy tied high
        clear_logs();
        c0 = cyc;
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (10) tick();
        chk("t1_count", xa.size(), 8);
        check_seq("t1", 0, 0, c0 + 1);
        chk("t1_done_count", dn.size(), 1);
        if (dn.size() > 0) chk("t1_done_cyc", dn[0], c0 + 9);
        chk("t1_cur_mode", int'(cur_mode), 0);

        // Mode 1 with a 3-cycle stall at index 2
        clear_logs();
        c0 = cyc;
        mode_sel = 1'b1; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (2) tick();
        C_rdy = 1'b0;
        tick();
        chk("t2_hold_valid", int'(C_valid), 1);
        chk("t2_hold_addr", int'(C_addr), 10);
        chk("t2_hold_data", int'(C_data), 6);
        repeat (2) tick();
        C_rdy = 1'b1;
        repeat (8) tick();
        chk("t2_count", xa.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < xd.size()) chk("t2_data", xd[i], E1[i]);
        end
        if (xc.size() == 8) begin
            chk("t2_cyc_idx2", xc[2], c0 + 6);
            chk("t2_cyc_idx7", xc[7], c0 + 11);
        end
        if (dn.size() > 0) chk("t2_done_cyc", dn[0], c0 + 12);
        chk("t2_cur_mode", int'(cur_mode), 1);

        // Request for mode 1 while mode 0 is running
        clear_logs();
        c0 = cyc;
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (2) tick();
        mode_sel = 1'b1; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (16) tick();
        chk("t3_count", xa.size(), 16);
        check_seq("t3a", 0, 0, c0 + 1);
        check_seq("t3b", 8, 1, c0 + 10);
        chk("t3_done_count", dn.size(), 2);
        if (dn.size() == 2) begin
            chk("t3_done0", dn[0], c0 + 9);
            chk("t3_done1", dn[1], c0 + 18);
        end
        chk("t3_cur_mode", int'(cur_mode), 1);

        // Two requests while busy collapse into one pending (last wins)
        clear_logs();
        c0 = cyc;
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        tick();
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        tick();
        mode_sel = 1'b1; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (20) tick();
        chk("t4_count", xa.size(), 16);
        check_seq("t4b", 8, 1, c0 + 10);
        chk("t4_done_count", dn.size(), 2);
        chk("t4_busy_end", int'(busy), 0);

        // Asynchronous reset in the middle of a write sequence
        clear_logs();
        mode_sel = 1'b1; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (2) tick();
        chk("t5_pre_valid", int'(C_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_C_valid", int'(C_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_cur_mode", int'(cur_mode), 0);
        chk("t5_C_addr", int'(C_addr), 8);
        chk("t5_C_data", int'(C_data), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t5_xfer_count", xa.size(), 2);
        chk("t5_busy_after", int'(busy), 0);
`else
        // Writes must wait for a VSync falling edge
        clear_logs();
        c0 = cyc;
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        repeat (18) tick();
        chk("t6_wait_count", xa.size(), 0);
        chk("t6_wait_valid", int'(C_valid), 0);
        chk("t6_wait_busy", int'(busy), 1);
        tick();
        VSync = 1'b0;
        tick();
        chk("t6_first_valid", int'(C_valid), 1);
        repeat (10) tick();
        VSync = 1'b1;
        chk("t6_count", xa.size(), 8);
        check_seq("t6", 0, 0, c0 + 21);
        if (dn.size() > 0) chk("t6_done_cyc", dn[0], c0 + 29);
        chk("t6_cur_mode", int'(cur_mode), 0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
